rv_inst_encoder: RTL and testbench

//  Encodes field-level instruction requests (class, op, rd, rs1, rs2, imm) into RV32I machine words.

---
 rtl/rv_inst_encoder.sv | 118 +++++++++++
 tb/tb_rv_inst_encoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv_inst_encoder.sv
// rv_inst_encoder: encodes field-level RV32I requests and writes them sequentially into instruction memory
module rv_inst_encoder #(
  parameter int ADDR_W = 8,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);
  typedef enum logic [2:0] {IDLE, ACCEPT, ENCODE, WRITE, DONE, ERR} state_t;
  state_t state, nxt;
  logic [3:0] kind, op;
  logic [4:0] rd, rs1, rs2;
  logic [31:0] imm;
  logic last, legal, alt, shift, in12;
  logic signed [31:0] s;
  logic [2:0] f3a;
  logic [6:0] f7;
  logic [31:0] word;
  assign s     = imm;
  assign alt   = op == 4'd1 || op == 4'd7;
  assign f7    = alt ? 7'b0100000 : 7'b0;
  assign shift = op == 4'd2 || op == 4'd6 || op == 4'd7;
  assign in12  = s >= -32'sd2048 && s <= 32'sd2047;
  // ALU op index to funct3: ADD/SUB share 0, SRL/SRA share 5
  assign f3a = op <= 4'd1 ? 3'd0 : op == 4'd2 ? 3'd1 : op == 4'd3 ? 3'd2 : op == 4'd4 ? 3'd3 :
               op == 4'd5 ? 3'd4 : op <= 4'd7 ? 3'd5 : op == 4'd8 ? 3'd6 : 3'd7;
  always_comb begin
    legal = 1'b0;
    word  = 32'd0;
    case (kind)
      4'd0: begin
        legal = op <= 4'd9;
        word  = {f7, rs2, rs1, f3a, rd, 7'b0110011};
      end
      4'd1: begin
        legal = op <= 4'd9 && op != 4'd1 && (shift ? imm[31:5] == 27'd0 : in12);
        word  = {shift ? {f7, imm[4:0]} : imm[11:0], rs1, f3a, rd, 7'b0010011};
      end
      4'd2: begin
        legal = op <= 4'd5 && op != 4'd3 && in12;
        word  = {imm[11:0], rs1, op[2:0], rd, 7'b0000011};
      end
      4'd3: begin
        legal = op == 4'd0 && in12;
        word  = {imm[11:0], rs1, 3'd0, rd, 7'b1100111};
      end
      4'd4: begin
        legal = op <= 4'd2 && in12;
        word  = {imm[11:5], rs2, rs1, op[2:0], imm[4:0], 7'b0100011};
      end
      4'd5: begin
        legal = (op <= 4'd1 || (op >= 4'd4 && op <= 4'd7)) && s >= -32'sd4096 && s <= 32'sd4094 && !imm[0];
        word  = {imm[12], imm[10:5], rs2, rs1, op[2:0], imm[4:1], imm[11], 7'b1100011};
      end
      4'd6, 4'd7: begin
        legal = imm[11:0] == 12'd0;
        word  = {imm[31:12], rd, kind == 4'd6 ? 7'b0110111 : 7'b0010111};
      end
      4'd8: begin
        legal = s >= -32'sd1048576 && s <= 32'sd1048574 && !imm[0];
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      end
      default: ;
    endcase
  end
  always_comb begin
    nxt = state;
    case (state)
      ACCEPT:  nxt = in_valid ? ENCODE : ACCEPT;
      ENCODE:  nxt = legal ? WRITE : ERR;
      WRITE:   nxt = last ? DONE : imem_addr == '1 ? ERR : ACCEPT;
      default: nxt = state;
    endcase
    if (start) nxt = ACCEPT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      imem_addr  <= ADDR_W'(BASE);
      imem_wdata <= 32'd0;
      count      <= '0;
      {kind, op, rd, rs1, rs2, imm, last} <= '0;
    end else begin
      state <= nxt;
      if (start) begin
        imem_addr <= ADDR_W'(BASE);
        count     <= '0;
      end else begin
        if (state == ACCEPT && in_valid) {kind, op, rd, rs1, rs2, imm, last} <= {in_kind, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last};
        if (state == ENCODE && legal) imem_wdata <= word;
        if (state == WRITE) count <= count + (ADDR_W+1)'(1);
        if (state == WRITE && nxt == ACCEPT) imem_addr <= imem_addr + ADDR_W'(1);
      end
    end
  end
  assign in_ready = state == ACCEPT;
  assign imem_we  = state == WRITE;
  assign busy     = state == ACCEPT || state == ENCODE || state == WRITE;
  assign done     = state == DONE;
  assign err      = state == ERR;
endmodule

// File: tb/tb_rv_inst_encoder.sv
// tb_rv_inst_encoder: directed stimulus checked every cycle against a timeline model of the encoder
module tb_rv_inst_encoder;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [3:0] in_kind = '0, in_op = '0;
  logic [4:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic in_ready, imem_we, busy, done, err;
  logic [7:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0] count;
  logic in_ready2, we2, busy2, done2, err2;
  logic [1:0] addr2;
  logic [31:0] wdata2;
  logic [2:0] count2;
  int checks = 0, errors = 0;
  rv_inst_encoder #(.ADDR_W(8), .BASE(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err), .count(count));
  rv_inst_encoder #(.ADDR_W(2), .BASE(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
    .in_kind(in_kind), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last), .imem_we(we2), .imem_addr(addr2),
    .imem_wdata(wdata2), .busy(busy2), .done(done2), .err(err2), .count(count2));
  always #5 clk = ~clk;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  // returns {legal, word}; fields assembled arithmetically from the ISA's bit positions
  function automatic longint menc(input int k, input int op, input int rd, input int rs1, input int rs2, input int imm);
    int f3tab[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    longint w = 0, u, f3, f7;
    bit lg = 0;
    f3 = (op <= 9) ? f3tab[op] : 0;
    f7 = (op == 1 || op == 7) ? 32 : 0;
    case (k)
      0: begin lg = op <= 9; w = (f7 << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h33; end
      1: begin
        if (op == 2 || op == 6 || op == 7) begin lg = imm >= 0 && imm <= 31; u = f7 * 32 + (imm & 31); end
        else begin lg = imm >= -2048 && imm <= 2047; u = imm & 'hFFF; end
        lg = lg && op <= 9 && op != 1;
        w = (u << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h13;
      end
      2: begin lg = (op inside {0, 1, 2, 4, 5}) && imm >= -2048 && imm <= 2047; w = (longint'(imm & 'hFFF) << 20) + (rs1 << 15) + (op << 12) + (rd << 7) + 'h03; end
      3: begin lg = op == 0 && imm >= -2048 && imm <= 2047; w = (longint'(imm & 'hFFF) << 20) + (rs1 << 15) + (rd << 7) + 'h67; end
      4: begin
        lg = (op inside {0, 1, 2}) && imm >= -2048 && imm <= 2047;
        u = imm & 'hFFF;
        w = ((u / 32) << 25) + (rs2 << 20) + (rs1 << 15) + (op << 12) + ((u % 32) << 7) + 'h23;
      end
      5: begin
        lg = (op inside {0, 1, 4, 5, 6, 7}) && imm >= -4096 && imm <= 4094 && imm % 2 == 0;
        u = imm & 'h1FFF;
        w = ((u / 4096) << 31) + (((u / 32) % 64) << 25) + (rs2 << 20) + (rs1 << 15) + (op << 12) +
            (((u / 2) % 16) << 8) + (((u / 2048) % 2) << 7) + 'h63;
      end
      6, 7: begin
        u = imm & 'hFFFFFFFF;
        lg = u % 4096 == 0;
        w = u - u % 4096 + (rd << 7) + (k == 6 ? 'h37 : 'h17);
      end
      8: begin
        lg = imm >= -1048576 && imm <= 1048574 && imm % 2 == 0;
        u = imm & 'h1FFFFF;
        w = ((u / 1048576) << 31) + (((u / 2) % 1024) << 21) + (((u / 2048) % 2) << 20) +
            (((u / 4096) % 256) << 12) + (rd << 7) + 'h6F;
      end
      default: lg = 0;
    endcase
    return (longint'(lg) << 32) | (w & 'hFFFFFFFF);
  endfunction
  // timeline model: each field holds the cycle index at which an event becomes visible (-1 = none)
  int cyc = 0, ready_at = -1, we_at = -1, done_at = -1, err_at = -1, cnt_at = -1, m_cnt = 0, m_addr = 0, we_addr = 0;
  bit sess = 0;
  longint we_data = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {ready_at, we_at, done_at, err_at, cnt_at} = {5{-1}};
      m_cnt = 0; m_addr = 0; sess = 0;
    end else begin
      automatic bit rdy = ready_at >= 0 && cyc >= ready_at;
      automatic longint e;
      cyc++;
      if (cnt_at >= 0 && cyc >= cnt_at) begin m_cnt++; cnt_at = -1; end
      if (start) begin
        sess = 1; ready_at = cyc; m_addr = 0; m_cnt = 0;
        {we_at, done_at, err_at, cnt_at} = {4{-1}};
      end else if (in_valid && rdy) begin
        ready_at = -1;
        e = menc(in_kind, in_op, in_rd, in_rs1, in_rs2, int'($signed(in_imm)));
        if (e[32]) begin
          we_at = cyc + 1; we_data = e & 'hFFFFFFFF; we_addr = m_addr; cnt_at = cyc + 2;
          if (in_last) done_at = cyc + 2;
          else if (m_addr == 255) err_at = cyc + 2;
          else begin ready_at = cyc + 2; m_addr++; end
        end else err_at = cyc + 1;
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      automatic bit ed = done_at >= 0 && cyc >= done_at;
      automatic bit ee = err_at >= 0 && cyc >= err_at;
      chk("in_ready", in_ready, ready_at >= 0 && cyc >= ready_at);
      chk("imem_we", imem_we, cyc == we_at);
      chk("done", done, ed);
      chk("err", err, ee);
      chk("busy", busy, sess && !ed && !ee);
      chk("count", count, m_cnt);
      if (cyc == we_at) begin
        chk("imem_addr", imem_addr, we_addr);
        chk("imem_wdata", imem_wdata, we_data);
      end
    end
  end
  int tcyc = 0, last_we = 0, gap = 0;
  logic [31:0] wq[$];
  logic [7:0] aq[$];
  logic [1:0] q2[$];
  always @(posedge clk) tcyc++;
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      wq.push_back(imem_wdata); aq.push_back(imem_addr);
      gap = tcyc - last_we; last_we = tcyc;
    end
    if (rst_n && we2) q2.push_back(addr2);
  end
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_start();
    start = 1'b1;
    idle(1);
    start = 1'b0;
    wq.delete(); aq.delete(); q2.delete();
  endtask
  task automatic send(input int k, input int op, input int rd, input int rs1, input int rs2, input int imm, input bit last);
    bit r = 0;
    in_valid = 1'b1; in_kind = 4'(k); in_op = 4'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
    in_imm = imm; in_last = last;
    for (int i = 0; i < 20 && !r; i++) begin
      @(negedge clk) r = in_ready;
      idle(1);
    end
    if (!r) begin errors++; checks++; $display("FAIL accept_timeout kind=%0d", k); end
    in_valid = 1'b0;
  endtask
  task automatic one(input int k, input int op, input int imm);
    do_start();
    send(k, op, 3, 1, 2, imm, 1'b1);
    idle(5);
  endtask
  initial begin
    chk("pin_addi", menc(1, 0, 1, 0, 0, 5), 64'h1_00500093);
    chk("pin_sub", menc(0, 1, 3, 1, 2, 0), 64'h1_402081B3);
    chk("pin_sw", menc(4, 2, 0, 1, 2, 8), 64'h1_0020A423);
    chk("pin_beq", menc(5, 0, 0, 1, 2, -4), 64'h1_FE208EE3);
    chk("pin_jal", menc(8, 0, 1, 0, 0, 8), 64'h1_008000EF);
    chk("pin_lui", menc(6, 0, 5, 0, 0, 'h12345000), 64'h1_123452B7);
    chk("pin_addi_2048", menc(1, 0, 1, 0, 0, 2048) >> 32, 0);
    chk("pin_beq_odd", menc(5, 0, 0, 1, 2, 3) >> 32, 0);
    #12;
    chk("rst_in_ready", in_ready, 0); chk("rst_we", imem_we, 0); chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_err", err, 0); chk("rst_count", count, 0);
    rst_n = 1'b1;
    idle(2);
    do_start();
    send(1, 0, 1, 0, 0, 5, 1'b1);
    idle(4);
    chk("addi_done", done, 1); chk("addi_count", count, 1); chk("addi_nwr", wq.size(), 1);
    if (wq.size() == 1) begin chk("addi_word", wq[0], 32'h00500093); chk("addi_addr", aq[0], 0); end
    do_start();
    send(0, 0, 3, 1, 2, 0, 1'b0);
    send(0, 1, 3, 1, 2, 0, 1'b1);
    idle(4);
    chk("addsub_nwr", wq.size(), 2); chk("addsub_gap", gap, 3);
    if (wq.size() == 2) begin
      chk("add_word", wq[0], 32'h002081B3); chk("sub_word", wq[1], 32'h402081B3); chk("sub_addr", aq[1], 1);
    end
    do_start();
    send(4, 2, 0, 1, 2, 8, 1'b0);
    send(5, 0, 0, 1, 2, -4, 1'b0);
    send(8, 0, 1, 0, 0, 8, 1'b0);
    send(6, 0, 5, 0, 0, 'h12345000, 1'b1);
    idle(4);
    chk("mix_nwr", wq.size(), 4); chk("mix_count", count, 4);
    if (wq.size() == 4) begin
      chk("sw_word", wq[0], 32'h0020A423); chk("beq_word", wq[1], 32'hFE208EE3);
      chk("jal_word", wq[2], 32'h008000EF); chk("lui_word", wq[3], 32'h123452B7);
    end
    one(1, 0, 2048);
    chk("addi2048_err", err, 1); chk("addi2048_nwr", wq.size(), 0); chk("addi2048_ready", in_ready, 0);
    one(5, 0, 3);
    chk("beq3_err", err, 1); chk("beq3_nwr", wq.size(), 0);
    one(1, 0, 2047); one(1, 0, -2048); one(1, 2, 31); one(1, 7, 31); one(1, 2, 32); one(1, 1, 0);
    one(1, 9, -1); one(0, 10, 0); one(0, 7, 0); one(9, 0, 0); one(2, 3, 0); one(2, 5, -2048);
    one(3, 1, 0); one(3, 0, 2047); one(4, 3, 0); one(4, 0, -2049); one(5, 2, 0); one(5, 7, 4094);
    one(5, 4, -4096); one(5, 0, 4096); one(8, 0, -1048576); one(8, 0, 1048574); one(8, 0, 1048576);
    one(6, 0, 'h800); one(7, 0, 'hFFFFF000); one(3, 0, -2);
    do_start();
    for (int i = 0; i < 5; i++) send(1, 0, 1, 0, 0, i, 1'b0);
    idle(4);
    chk("full_err", err2, 1); chk("full_count", count2, 4); chk("full_nwr", q2.size(), 4);
    foreach (q2[i]) chk("full_addr", q2[i], i);
    do_start();
    send(0, 0, 3, 1, 2, 0, 1'b0);
    idle(2);
    wq.delete();
    in_valid = 1'b1; start = 1'b1; in_kind = 4'd0; in_last = 1'b1;
    idle(1);
    start = 1'b0; in_valid = 1'b0;
    idle(5);
    chk("restart_nwr", wq.size(), 0); chk("restart_count", count, 0); chk("restart_addr", imem_addr, 0);
    chk("restart_ready", in_ready, 1); chk("restart_err", err, 0); chk("restart_done", done, 0);
    do_start();
    send(1, 0, 1, 0, 0, 5, 1'b0);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_count", count, 0); chk("mrst_addr", imem_addr, 0); chk("mrst_wdata", imem_wdata, 0);
    chk("mrst_ready", in_ready, 0); chk("mrst_busy", busy, 0);
    idle(1);
    rst_n = 1'b1;
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
